angle_read_scheduler: RTL and testbench
=======================================

# angle_read_scheduler

Shares the single I2C master between the four swerve-wheel encoders, which sit behind a 4-channel I2C mux. It round-robins angle reads across the enabled wheels and latches each 12-bit result. It then presents the value and a per-wheel `rd_done` level to that wheel's `pid` instance, which edge-detects it.

## Interface
- `ANGLE_REG`, 8'h0C: encoder register address issued with every read (raw angle high byte).
- `GAP_CYCLES`, 8: idle cycles between consecutive transactions (8-bit counter; 0 = back-to-back).
- `TIMEOUT_CYCLES`, 20000: max cycles from `i2c_start` to `i2c_done`/`i2c_error` (16-bit counter).
- `clock` in 1: the main clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `wheel_enable` in 4: per-wheel read enable; bit n = wheel n.
- `clear_faults` in 1: one-cycle pulse that clears all `read_fault` bits.
- `i2c_busy` in 1: I2C master busy; no start is issued while high.
- `i2c_done` in 1: one-cycle pulse, read complete, `i2c_rd_data` valid the same cycle.
- `i2c_error` in 1: one-cycle pulse, NACK or bus error on the current transaction.
- `i2c_rd_data` in 16: read data; bits [11:0] are the angle, bits [15:12] are ignored.
- `i2c_start` out 1: one-cycle transaction request.
- `i2c_channel` out 2: mux channel (= wheel index) for the current transaction; held stable from start until done, error or timeout.
- `i2c_reg_addr` out 8: always `ANGLE_REG`.
- `angle_out` out 48: packed angles, wheel n at [12n+11:12n].
- `rd_done` out 4: per-wheel level; rises when a fresh angle is latched and falls when the next read of that wheel is issued.
- `read_fault` out 4: sticky per-wheel fault (error or timeout).
- `sched_busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - If `wheel_enable` is nonzero, select the next enabled wheel after `last_served`, searching upward modulo 4.
  - Load the wheel into `cur_wheel`, drive `i2c_channel`, go to ISSUE.
  - If `wheel_enable` is zero, stay in IDLE.
- ISSUE:
  - When `i2c_busy` is 0: pulse `i2c_start`, clear `rd_done[cur_wheel]`, clear the timeout counter, go to WAIT.
  - Otherwise wait in ISSUE; the timeout does not run here.
- WAIT: the timeout counter increments every cycle. The first matching condition applies:
  - `i2c_done`: if `wheel_enable[cur_wheel]` is still 1, latch `i2c_rd_data[11:0]` into the wheel's `angle_out` slice and set `rd_done[cur_wheel]`. If the wheel has been disabled, discard the data and leave `rd_done` low. Go to GAP.
  - `i2c_error`: set `read_fault[cur_wheel]`, leave the angle unchanged, go to GAP.
  - Counter reaches `TIMEOUT_CYCLES`-1: set `read_fault[cur_wheel]`, go to GAP. A late `i2c_done` after this point is ignored.
  - `i2c_done` and `i2c_error` in the same cycle: error wins.
- GAP: set `last_served` = `cur_wheel`. Count `GAP_CYCLES` cycles, then go to IDLE. With `GAP_CYCLES`=0, go to IDLE on the next cycle.
- Disabled wheels are skipped. A single enabled wheel is read repeatedly.
- `clear_faults` clears `read_fault` the same cycle. If it coincides with a new fault, the new fault wins and its bit stays set.
- A fault does not remove the wheel from rotation; it is retried on its next turn.

## Timing
- Reset values:
  - state IDLE, `i2c_start` 0, `i2c_channel` 0, `i2c_reg_addr` `ANGLE_REG`.
  - `angle_out` 0, `rd_done` 0, `read_fault` 0, `sched_busy` 0.
  - `last_served` 3, so wheel 0 is served first.
- Reset mid-transaction returns to IDLE. Any `i2c_done` or `i2c_error` arriving afterwards is ignored in IDLE.
- Latency:
  - IDLE→ISSUE: 1 cycle.
  - ISSUE→`i2c_start`: the cycle in which `i2c_busy` is 0 (registered output, visible the next edge).
  - `i2c_done`→`angle_out`/`rd_done` update: 1 cycle.
- Round-trip per wheel = 2 + I2C time + `GAP_CYCLES` + 1 cycles.
- `rd_done` stays low for at least 1 cycle per read, so the PID edge detector sees exactly one rising edge per fresh angle.

## Test plan
- Reset, `wheel_enable`=4'b1111, I2C model answers after 10 cycles with wheel-specific data 0x0A0n -> `i2c_channel` sequence 0,1,2,3,0; each wheel's `angle_out` slice = 12'hA0n; one `rd_done` rising edge per read.
- `wheel_enable`=4'b0101 -> only channels 0,2,0,2 are issued; `rd_done[1]` and `rd_done[3]` stay 0.
- Wheel 1 model returns `i2c_error` -> `read_fault`=4'b0010 and wheel 1 angle unchanged. Pulse `clear_faults` -> `read_fault`=0. Wheel 1 is retried on its next turn.
- Model never answers wheel 2, `TIMEOUT_CYCLES`=100 -> `read_fault[2]` set 100 cycles after start; a late `i2c_done` is ignored; the scheduler proceeds to wheel 3.
- Hold `i2c_busy`=1 for 50 cycles during ISSUE -> no `i2c_start` and no fault; start occurs the cycle after `i2c_busy` falls.
- Assert `reset` during WAIT, then model pulses `i2c_done` -> all outputs at reset values, no angle latched; the next read targets wheel 0.

Source files
------------

// File: rtl/angle_read_scheduler.sv
// angle_read_scheduler
//   Shares one I2C master between four swerve-wheel encoders that sit behind a
//   4-channel I2C mux. Reads are round-robined across the enabled wheels. Each
//   12-bit angle is latched per wheel, and a per-wheel rd_done level is raised
//   for the downstream pid instance, which edge-detects it.
//
// Ports
//   clock, reset        : main clock, synchronous active-high reset
//   wheel_enable[3:0]   : per-wheel read enable
//   clear_faults        : pulse, clears read_fault (a fault raised the same cycle wins)
//   i2c_busy            : master busy, holds off i2c_start
//   i2c_done/i2c_error  : one-cycle completion / failure pulses from the master
//   i2c_rd_data[15:0]   : read data, [11:0] = angle
//   i2c_start           : one-cycle transaction request (registered)
//   i2c_channel[1:0]    : mux channel = wheel being read, stable for the whole transaction
//   i2c_reg_addr[7:0]   : constant ANGLE_REG
//   angle_out[47:0]     : wheel n angle at [12n+11:12n]
//   rd_done[3:0]        : per-wheel fresh-angle level
//   read_fault[3:0]     : sticky per-wheel error/timeout flag
//   sched_busy          : scheduler not in IDLE

// Per-wheel result holder: angle register, rd_done level and sticky fault.
// Only the lane selected by the scheduler reacts to start/latch/fault.
module angle_read_lane #(
  parameter int ANGLE_W = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sel,
  input  logic               start,
  input  logic               latch,
  input  logic               fault,
  input  logic               clear_faults,
  input  logic [ANGLE_W-1:0] data,
  output logic [ANGLE_W-1:0] angle,
  output logic               rd_done,
  output logic               read_fault
);

  always_ff @(posedge clock) begin
    if (reset) begin
      angle      <= '0;
      rd_done    <= 1'b0;
      read_fault <= 1'b0;
    end else begin
      // rd_done drops when the read is issued and rises only when a fresh
      // angle lands, so the consumer sees exactly one rising edge per angle.
      if (sel && start) begin
        rd_done <= 1'b0;
      end else if (sel && latch) begin
        rd_done <= 1'b1;
        angle   <= data;
      end
      // A new fault takes priority over a coincident clear.
      if (sel && fault) begin
        read_fault <= 1'b1;
      end else if (clear_faults) begin
        read_fault <= 1'b0;
      end
    end
  end

endmodule

module angle_read_scheduler #(
  parameter logic [7:0]  ANGLE_REG      = 8'h0C,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  wheel_enable,
  input  logic        clear_faults,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_error,
  input  logic [15:0] i2c_rd_data,
  output logic        i2c_start,
  output logic [1:0]  i2c_channel,
  output logic [7:0]  i2c_reg_addr,
  output logic [47:0] angle_out,
  output logic [3:0]  rd_done,
  output logic [3:0]  read_fault,
  output logic        sched_busy
);

  localparam int NUM_WHEELS = 4;
  localparam int ANGLE_W    = 12;

  // Terminal counts: GAP holds for GAP_CYCLES+1 cycles (one cycle when 0);
  // WAIT gives up after TIMEOUT_CYCLES cycles counted from the start pulse.
  localparam logic [7:0]  GAP_LAST = GAP_CYCLES[7:0];
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cur_wheel;
  logic [1:0]  last_served;
  logic [1:0]  next_wheel;
  logic [15:0] tcnt;
  logic [7:0]  gcnt;

  logic        load_wheel;
  logic        go_start;
  logic        latch_angle;
  logic        set_fault;

  logic [NUM_WHEELS-1:0][ANGLE_W-1:0] angle_q;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^i2c_rd_data[15:12];

  // Round-robin pick: first enabled wheel above last_served, wrapping. The
  // loop runs from the farthest offset down so the nearest one wins; offset 4
  // wraps to last_served itself, which lets a lone enabled wheel repeat.
  always_comb begin
    next_wheel = last_served;
    for (int i = NUM_WHEELS; i >= 1; i--) begin
      if (wheel_enable[last_served + 2'(i)]) begin
        next_wheel = last_served + 2'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_wheel  = 1'b0;
    go_start    = 1'b0;
    latch_angle = 1'b0;
    set_fault   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|wheel_enable) begin
          load_wheel = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i2c_busy) begin
          go_start  = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // error beats done; done beats a timeout landing the same cycle
        if (i2c_error) begin
          set_fault = 1'b1;
          state_nxt = S_GAP;
        end else if (i2c_done) begin
          // a wheel disabled mid-read gets its data dropped
          latch_angle = wheel_enable[cur_wheel];
          state_nxt   = S_GAP;
        end else if (tcnt == TO_LAST) begin
          set_fault = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i2c_start   <= 1'b0;
      cur_wheel   <= 2'd0;
      last_served <= 2'd3;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      i2c_start <= go_start;
      if (load_wheel) begin
        cur_wheel <= next_wheel;
      end
      // Timeout only runs in WAIT; busy stalls in ISSUE never count.
      if (go_start) begin
        tcnt <= '0;
      end else if (state == S_WAIT) begin
        tcnt <= tcnt + 16'd1;
      end
      if (state == S_GAP) begin
        last_served <= cur_wheel;
        gcnt        <= gcnt + 8'd1;
      end else begin
        gcnt <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_WHEELS; g++) begin : g_lane
    angle_read_lane #(.ANGLE_W(ANGLE_W)) u_lane (
      .clock        (clock),
      .reset        (reset),
      .sel          (cur_wheel == 2'(g)),
      .start        (go_start),
      .latch        (latch_angle),
      .fault        (set_fault),
      .clear_faults (clear_faults),
      .data         (i2c_rd_data[ANGLE_W-1:0]),
      .angle        (angle_q[g]),
      .rd_done      (rd_done[g]),
      .read_fault   (read_fault[g])
    );
  end

  assign angle_out    = angle_q;
  assign i2c_channel  = cur_wheel;
  assign i2c_reg_addr = ANGLE_REG;
  assign sched_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_angle_read_scheduler.sv
// Bench for angle_read_scheduler: a directed vector table following the main
// scenarios, hand sequences for busy stall and mid-read reset, then a random
// run checked against a behavioural model of the round-robin rules.
module tb_angle_read_scheduler;

  localparam int GAP = 4;
  localparam int TO  = 100;
  localparam int LAT = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wheel_enable = 4'h0;
  logic        clear_faults = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_error = 1'b0;
  logic [15:0] i2c_rd_data = 16'h0;
  logic        i2c_start;
  logic [1:0]  i2c_channel;
  logic [7:0]  i2c_reg_addr;
  logic [47:0] angle_out;
  logic [3:0]  rd_done;
  logic [3:0]  read_fault;
  logic        sched_busy;

  angle_read_scheduler #(
    .ANGLE_REG(8'h0C), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .wheel_enable(wheel_enable),
    .clear_faults(clear_faults), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
    .i2c_error(i2c_error), .i2c_rd_data(i2c_rd_data), .i2c_start(i2c_start),
    .i2c_channel(i2c_channel), .i2c_reg_addr(i2c_reg_addr),
    .angle_out(angle_out), .rd_done(rd_done), .read_fault(read_fault),
    .sched_busy(sched_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // response modes: 0 done, 1 error, 2 done+error together, 3 no answer, 4 error with clear_faults
  typedef struct {
    logic [3:0]  en;
    logic [3:0]  en_mid;
    logic        clr;
    int          mode;
    logic [15:0] data;
    logic [1:0]  ch;
    logic [11:0] ang;
    logic [3:0]  flt;
    logic        rd;
  } vec_t;

  vec_t tbl [18];

  // next enabled wheel strictly after 'last', wrapping; itself if it is the only one
  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] en);
    logic [1:0] w;
    for (int i = 1; i <= 4; i++) begin
      w = last + 2'(i);
      if (en[w]) return w;
    end
    return last;
  endfunction

  task automatic wait_start(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (i2c_start) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
    n_chk++;
    $display("FAIL wait_start: got no i2c_start expected one within 400 cycles");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, 64'(i2c_start), 64'(0));
    chk({tag, "_channel"}, 64'(i2c_channel), 64'(0));
    chk({tag, "_reg_addr"}, 64'(i2c_reg_addr), 64'(8'h0C));
    chk({tag, "_angle"}, 64'(angle_out), 64'(0));
    chk({tag, "_rd_done"}, 64'(rd_done), 64'(0));
    chk({tag, "_fault"}, 64'(read_fault), 64'(0));
    chk({tag, "_busy"}, 64'(sched_busy), 64'(0));
  endtask

  task automatic do_reset(input logic [3:0] en);
    reset = 1'b1;
    i2c_done = 1'b0; i2c_error = 1'b0; clear_faults = 1'b0; i2c_busy = 1'b0;
    wheel_enable = en;
    @(negedge clock);
    @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
  endtask

  // Called at the negedge where i2c_start is visible. Answers 'lat' cycles
  // later; in no-answer mode checks the fault lands exactly TO cycles after
  // start, then sends a late done that must be ignored.
  task automatic respond(input int mode, input int lat, input logic [15:0] data,
                         input logic [1:0] ch, input logic pre_fault);
    int n;
    n = (mode == 3) ? TO - 1 : lat;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      clear_faults = 1'b0;
    end
    if (mode == 3) begin
      chk("fault_before_timeout", 64'(read_fault[ch]), 64'(pre_fault));
      @(negedge clock);
      chk("fault_at_timeout", 64'(read_fault[ch]), 64'(1));
      i2c_rd_data = data;
      i2c_done = 1'b1;
    end else begin
      i2c_rd_data  = data;
      i2c_done     = (mode == 0) || (mode == 2);
      i2c_error    = (mode != 0);
      clear_faults = (mode == 4);
    end
    @(negedge clock);
    i2c_done = 1'b0;
    i2c_error = 1'b0;
    clear_faults = 1'b0;
    i2c_rd_data = 16'($urandom);
  endtask

  bit          ok;
  int          at, prev_at, prev_mode, prev_lat, starts_seen;
  bit          have_prev;
  logic        pre;
  logic [1:0]  ech;
  logic [1:0]  m_last;
  logic [3:0]  m_rd, m_flt;
  logic [3:0][11:0] m_ang;
  int          mode, lat;
  logic [15:0] data;

  initial begin
    //          en     en_mid clr  mode data      ch    ang      flt    rd
    tbl[0]  = '{4'hF, 4'hF, 1'b0, 0, 16'h0A00, 2'd0, 12'hA00, 4'b0000, 1'b1};
    tbl[1]  = '{4'hF, 4'hF, 1'b0, 0, 16'h0A01, 2'd1, 12'hA01, 4'b0000, 1'b1};
    tbl[2]  = '{4'hF, 4'hF, 1'b0, 0, 16'h0A02, 2'd2, 12'hA02, 4'b0000, 1'b1};
    tbl[3]  = '{4'hF, 4'hF, 1'b0, 0, 16'hFA03, 2'd3, 12'hA03, 4'b0000, 1'b1};
    tbl[4]  = '{4'hF, 4'hF, 1'b0, 0, 16'h0A10, 2'd0, 12'hA10, 4'b0000, 1'b1};
    tbl[5]  = '{4'hF, 4'hF, 1'b0, 1, 16'h0EEE, 2'd1, 12'hA01, 4'b0010, 1'b0};
    tbl[6]  = '{4'h5, 4'h5, 1'b0, 0, 16'h0B02, 2'd2, 12'hB02, 4'b0010, 1'b1};
    tbl[7]  = '{4'h5, 4'h5, 1'b0, 2, 16'h0B00, 2'd0, 12'hA10, 4'b0011, 1'b0};
    tbl[8]  = '{4'h5, 4'h5, 1'b0, 0, 16'h0B12, 2'd2, 12'hB12, 4'b0011, 1'b1};
    tbl[9]  = '{4'h5, 4'h5, 1'b0, 0, 16'h0B10, 2'd0, 12'hB10, 4'b0011, 1'b1};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 0, 16'h0A11, 2'd1, 12'hA11, 4'b0000, 1'b1};
    tbl[11] = '{4'hF, 4'hF, 1'b0, 3, 16'h0DEA, 2'd2, 12'hB12, 4'b0100, 1'b0};
    tbl[12] = '{4'hF, 4'hF, 1'b0, 0, 16'h0A33, 2'd3, 12'hA33, 4'b0100, 1'b1};
    tbl[13] = '{4'hF, 4'hF, 1'b0, 4, 16'h0777, 2'd0, 12'hB10, 4'b0001, 1'b0};
    tbl[14] = '{4'hF, 4'hD, 1'b0, 0, 16'h0CCC, 2'd1, 12'hA11, 4'b0001, 1'b0};
    tbl[15] = '{4'hD, 4'hD, 1'b0, 0, 16'h0A22, 2'd2, 12'hA22, 4'b0001, 1'b1};
    tbl[16] = '{4'h4, 4'h4, 1'b0, 0, 16'h0A42, 2'd2, 12'hA42, 4'b0001, 1'b1};
    tbl[17] = '{4'h4, 4'h4, 1'b0, 0, 16'h0A52, 2'd2, 12'hA52, 4'b0001, 1'b1};

    // ---- directed table ----
    do_reset(4'hF);
    have_prev = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wheel_enable = tbl[i].en;
      wait_start(ok, at);
      if (have_prev)
        chk($sformatf("interval[%0d]", i), 64'(at - prev_at),
            64'((prev_mode == 3) ? TO + GAP + 3 : LAT + GAP + 4));
      chk($sformatf("channel[%0d]", i), 64'(i2c_channel), 64'(tbl[i].ch));
      chk($sformatf("start_rd_low[%0d]", i), 64'(rd_done[tbl[i].ch]), 64'(0));
      pre = 1'b0;
      if (i > 0 && !tbl[i].clr) pre = tbl[i-1].flt[tbl[i].ch];
      wheel_enable = tbl[i].en_mid;
      clear_faults = tbl[i].clr;
      respond(tbl[i].mode, LAT, tbl[i].data, tbl[i].ch, pre);
      chk($sformatf("angle[%0d]", i), 64'(angle_out[12*int'(tbl[i].ch) +: 12]), 64'(tbl[i].ang));
      chk($sformatf("fault[%0d]", i), 64'(read_fault), 64'(tbl[i].flt));
      chk($sformatf("rd_done[%0d]", i), 64'(rd_done[tbl[i].ch]), 64'(tbl[i].rd));
      have_prev = 1'b1; prev_at = at; prev_mode = tbl[i].mode;
    end

    // ---- busy holds the scheduler in ISSUE for 50 cycles ----
    i2c_busy = 1'b1;
    starts_seen = 0;
    repeat (50) begin
      @(negedge clock);
      if (i2c_start) starts_seen++;
    end
    chk("busy_no_start", 64'(starts_seen), 64'(0));
    chk("busy_no_fault", 64'(read_fault), 64'(4'b0001));
    i2c_busy = 1'b0;
    @(negedge clock);
    chk("busy_release_start", 64'(i2c_start), 64'(1));
    chk("busy_release_channel", 64'(i2c_channel), 64'(2));
    respond(0, LAT, 16'h0A62, 2'd2, 1'b0);
    chk("busy_angle", 64'(angle_out[35:24]), 64'(12'hA62));

    // ---- reset while waiting, then a stray done ----
    wheel_enable = 4'hF;
    wait_start(ok, at);
    chk("pre_reset_channel", 64'(i2c_channel), 64'(3));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("midreset");
    reset = 1'b0;
    i2c_rd_data = 16'h0ABC;
    i2c_done = 1'b1;
    @(negedge clock);
    i2c_done = 1'b0;
    chk("stray_done_angle", 64'(angle_out), 64'(0));
    chk("stray_done_rd", 64'(rd_done), 64'(0));
    wait_start(ok, at);
    chk("after_reset_channel", 64'(i2c_channel), 64'(0));
    respond(0, LAT, 16'h0123, 2'd0, 1'b0);
    chk("after_reset_angle", 64'(angle_out), 64'(48'h123));

    // ---- randomized run against the model ----
    do_reset(4'($urandom_range(1, 15)));
    m_last = 2'd3; m_rd = '0; m_flt = '0; m_ang = '0;
    have_prev = 1'b0;
    for (int t = 0; t < 60; t++) begin
      wait_start(ok, at);
      if (!ok) break;
      if (have_prev)
        chk($sformatf("r_interval[%0d]", t), 64'(at - prev_at),
            64'((prev_mode == 3) ? TO + GAP + 3 : prev_lat + GAP + 4));
      ech = pick(m_last, wheel_enable);
      chk($sformatf("r_channel[%0d]", t), 64'(i2c_channel), 64'(ech));
      m_rd[ech] = 1'b0;
      chk($sformatf("r_rd_done[%0d]", t), 64'(rd_done), 64'(m_rd));
      chk($sformatf("r_angle[%0d]", t), 64'(angle_out), 64'(m_ang));
      chk($sformatf("r_fault[%0d]", t), 64'(read_fault), 64'(m_flt));
      clear_faults = ($urandom_range(0, 7) == 0);
      if (clear_faults) m_flt = '0;
      if ($urandom_range(0, 3) == 0) wheel_enable = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 99)) inside
        [0:69]:  mode = 0;
        [70:81]: mode = 1;
        [82:87]: mode = 2;
        [88:92]: mode = 4;
        default: mode = 3;
      endcase
      lat  = $urandom_range(1, 12);
      data = 16'($urandom);
      respond(mode, lat, data, ech, m_flt[ech]);
      if (mode == 0) begin
        if (wheel_enable[ech]) begin
          m_ang[ech] = data[11:0];
          m_rd[ech]  = 1'b1;
        end
      end else begin
        if (mode == 4) m_flt = '0;
        m_flt[ech] = 1'b1;
      end
      m_last = ech;
      have_prev = 1'b1; prev_at = at; prev_mode = mode; prev_lat = lat;
    end
    chk("r_final_angle", 64'(angle_out), 64'(m_ang));
    chk("r_final_fault", 64'(read_fault), 64'(m_flt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
